// File: rtl/div_unit.sv
// Multi-cycle 32-bit integer divider for div/divu. It uses radix-2 restoring
// division on magnitudes, with sign fix-up applied when the result is presented.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic [63:0] result,
    output logic        ready,
    output logic        stall_req
);

    typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

    state_t      state;
    logic [5:0]  count;
    logic [31:0] divisor;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        neg_q;
    logic        neg_r;
    logic [63:0] result_q;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] partial;
    logic [32:0] diff;
    logic [31:0] fixed_q;
    logic [31:0] fixed_r;
    logic [63:0] final_res;

    assign a_mag = (signed_div && a[31]) ? -a : a;
    assign b_mag = (signed_div && b[31]) ? -b : b;

    // One restoring step: shift the next dividend bit into the remainder, then
    // subtract the divisor. A borrow in bit 32 means the step must not keep the difference.
    assign partial = {rem, quo[31]};
    assign diff    = partial - {1'b0, divisor};

    assign fixed_q   = neg_q ? -quo : quo;
    assign fixed_r   = neg_r ? -rem : rem;
    assign final_res = {fixed_r, fixed_q};

    // A cancel in the DONE cycle suppresses the pulse and keeps the old result visible.
    assign ready     = (state == DONE) && !cancel;
    assign result    = ready ? final_res : result_q;
    assign stall_req = start & ~ready & ~cancel;

    // NOTE: every register here is sequential state, so it uses non-blocking
    // assignments only. A blocking assignment would let later statements see
    // the new value in the same edge and would create simulation races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= 6'd0;
            divisor  <= 32'd0;
            quo      <= 32'd0;
            rem      <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= 64'h0;
        end else if (cancel) begin
            state <= IDLE;
            count <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        divisor <= b_mag;
                        quo     <= a_mag;
                        rem     <= 32'd0;
                        neg_q   <= signed_div & (a[31] ^ b[31]);
                        neg_r   <= signed_div & a[31];
                        count   <= 6'd0;
                        state   <= (b == 32'd0) ? DIVZERO : BUSY;
                    end
                end
                DIVZERO: begin
                    quo   <= 32'd0;
                    rem   <= 32'd0;
                    state <= DONE;
                end
                BUSY: begin
                    if (!diff[32]) begin
                        rem <= diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= partial[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    result_q <= final_res;
                    count    <= 6'd0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit. Drivers push the expected results, and a monitor
// pops one entry on every ready pulse and compares it with the result.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic [63:0] result;
    logic        ready;
    logic        stall_req;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb[$];

    div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .cancel     (cancel),
        .result     (result),
        .ready      (ready),
        .stall_req  (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sample 3 time units after the negedge. By then the driver has applied its changes.
    always @(negedge clk) begin
        #3;
        if (ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                logic [63:0] exp;
                exp = sb.pop_front();
                check("result", result, exp);
            end
        end
    end

    // Advance to the apply point of the next cycle, which is 1 time unit after the negedge.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // The caller is at the apply point of cycle 0. The task returns at the
    // sample point of the ready cycle.
    task automatic run_op(input string name, input logic sd, input logic [31:0] ai,
                          input logic [31:0] bi, input logic [63:0] exp, input int lat,
                          input bit hold, input int drop_k);
        int got;
        int stall_bad;
        got = -1;
        stall_bad = 0;
        start = 1'b1;
        signed_div = sd;
        a = ai;
        b = bi;
        sb.push_back(exp);
        for (int k = 0; k <= lat + 3; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            if (k == 2) begin
                a = $urandom;
                b = $urandom;
            end
            if (k == drop_k) start = 1'b0;
            #1;
            if (ready && k > 0) begin
                got = k;
                break;
            end
            if (start && !ready && !stall_req) stall_bad++;
        end
        check({name, "_latency"}, 64'(got), 64'(lat));
        check({name, "_stall"}, 64'(stall_bad), 64'd0);
        if (got >= 0) check({name, "_stall_at_ready"}, {63'd0, stall_req}, 64'd0);
        if (!hold) start = 1'b0;
    endtask

    // Issue an unsigned operation and cancel it in cycle ck. The task returns at
    // the apply point of cycle ck+1 with cancel and start low.
    task automatic run_cancel(input string name, input logic [31:0] ai, input logic [31:0] bi,
                              input int ck);
        start = 1'b1;
        signed_div = 1'b0;
        a = ai;
        b = bi;
        for (int k = 0; k <= ck; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            if (k == 2) begin
                a = $urandom;
                b = $urandom;
            end
            if (k == ck) cancel = 1'b1;
            #1;
            if (k == ck) begin
                check({name, "_stall"}, {63'd0, stall_req}, 64'd0);
                check({name, "_ready"}, {63'd0, ready}, 64'd0);
            end
        end
        @(negedge clk);
        #1;
        cancel = 1'b0;
        start  = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        signed_div = 1'b0;
        a = 32'd0;
        b = 32'd0;
        cancel = 1'b0;

        idle(2);
        check("reset_result", result, 64'h0);
        check("reset_ready", {63'd0, ready}, 64'd0);
        start = 1'b1;
        #1;
        check("reset_stall_follows_start", {63'd0, stall_req}, 64'd1);
        start = 1'b0;
        idle(1);
        reset = 1'b1;
        idle(1);

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0, -1);
        idle(3);
        check("result_hold", result, {32'd2, 32'd14});

        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0, -1);
        idle(1);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 1'b0, -1);
        idle(1);
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 64'h0, 2, 1'b0, -1);
        idle(1);
        run_op("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 1'b0, -1);
        idle(1);
        run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 33, 1'b0, -1);
        idle(1);
        run_op("div_5_0", 1'b1, 32'd5, 32'd0, 64'h0, 2, 1'b0, -1);
        idle(1);
        run_op("divu_7_100", 1'b0, 32'd7, 32'd100, {32'd7, 32'd0}, 33, 1'b0, -1);
        idle(1);

        // Cancel during BUSY, then start a new operation in the next cycle.
        run_cancel("cancel_busy", 32'd100, 32'd7, 10);
        check("cancel_result_kept", result, {32'd7, 32'd0});
        run_op("divu_9_3_after_cancel", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0, -1);
        idle(1);

        // A cancel in the DONE cycle suppresses both the ready pulse and the result update.
        run_cancel("cancel_done", 32'd20, 32'd4, 33);
        idle(2);
        check("cancel_done_result_kept", result, {32'd0, 32'd3});
        run_cancel("cancel_divzero", 32'd5, 32'd0, 1);
        idle(2);
        check("cancel_divzero_result_kept", result, {32'd0, 32'd3});

        // Dropping start mid-operation does not abort the operation.
        run_op("divu_start_drop", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33, 1'b0, 5);
        idle(1);

        // Back-to-back divides with start held across the ready cycle.
        run_op("b2b_first", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33, 1'b1, -1);
        run_op("b2b_second", 1'b0, 32'hFFFF_FFFF, 32'd16, {32'h0000_000F, 32'h0FFF_FFFF}, 34, 1'b0, -1);
        idle(1);

        // Assert reset in cycle 15 of a BUSY operation.
        start = 1'b1;
        signed_div = 1'b0;
        a = 32'd100;
        b = 32'd7;
        idle(15);
        reset = 1'b0;
        #1;
        check("midreset_result", result, 64'h0);
        check("midreset_ready", {63'd0, ready}, 64'd0);
        check("midreset_stall", {63'd0, stall_req}, 64'd1);
        idle(2);
        start = 1'b0;
        reset = 1'b1;
        idle(1);
        run_op("divu_after_reset", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0, -1);
        idle(5);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
